// File: rtl/out_channel_reader.sv
// out_channel_reader: captures program out-channel words into a FIFO and streams them to the host.
module out_channel_reader #(
  parameter int MemoryElementWidth = 12,
  parameter int Depth = 4,
  parameter int CountWidth = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          out_we,
  input  logic [MemoryElementWidth-1:0] out_data,
  input  logic                          prog_finished,
  output logic                          rd_valid,
  output logic [MemoryElementWidth-1:0] rd_data,
  input  logic                          rd_ready,
  output logic [CountWidth-1:0]         words_in,
  output logic [CountWidth-1:0]         words_out,
  output logic                          overflow,
  output logic                          protocol_error,
  output logic                          done
);
  localparam int AW = $clog2(Depth);
  localparam int FW = AW + 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [MemoryElementWidth-1:0] mem [Depth];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [CountWidth-1:0] words_in_q, words_in_d, words_out_q, words_out_d;
  logic overflow_q, overflow_d, perr_q, perr_d;
  logic run, hs, room, wr_ok;
  assign rd_valid       = fill_q != '0 && state_q != IDLE;
  assign rd_data        = rd_valid ? mem[rd_ptr_q] : '0;
  assign words_in       = words_in_q;
  assign words_out      = words_out_q;
  assign overflow       = overflow_q;
  assign protocol_error = perr_q;
  assign done           = state_q == DONE;
  always_comb begin
    run         = state_q == RUN;
    hs          = rd_valid && rd_ready;
    // a full FIFO still takes a write when the head leaves in the same cycle
    room        = fill_q != FW'(Depth) || hs;
    wr_ok       = run && out_we && room && !start;
    state_d     = start ? RUN
                : run && prog_finished ? DRAIN
                : state_q == DRAIN && fill_q == '0 ? DONE
                : state_q;
    rd_ptr_d    = start ? '0 : rd_ptr_q + AW'(hs);
    wr_ptr_d    = start ? '0 : wr_ptr_q + AW'(wr_ok);
    fill_d      = start ? '0 : fill_q + FW'(wr_ok) - FW'(hs);
    words_in_d  = start ? '0 : wr_ok && ~&words_in_q ? words_in_q + CountWidth'(1) : words_in_q;
    words_out_d = start ? '0 : hs && ~&words_out_q ? words_out_q + CountWidth'(1) : words_out_q;
    overflow_d  = !start && (overflow_q || (run && out_we && !room));
    perr_d      = !start && (perr_q || (out_we && !run));
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      words_in_q  <= '0;
      words_out_q <= '0;
      overflow_q  <= 1'b0;
      perr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      words_in_q  <= words_in_d;
      words_out_q <= words_out_d;
      overflow_q  <= overflow_d;
      perr_q      <= perr_d;
    end
  end
  always_ff @(posedge clock)
    if (wr_ok && !reset) mem[wr_ptr_q] <= out_data;
endmodule

// File: tb/tb_out_channel_reader.sv
// tb_out_channel_reader: directed checks of capture, delivery, flags and sequencing.
module tb_out_channel_reader;
  logic clock = 0, reset, start, out_we, prog_finished, rd_ready;
  logic [11:0] out_data, rd_data;
  logic rd_valid, overflow, protocol_error, done;
  logic [15:0] words_in, words_out;
  int checks = 0, errors = 0;
  out_channel_reader dut (
    .clock(clock), .reset(reset), .start(start), .out_we(out_we), .out_data(out_data),
    .prog_finished(prog_finished), .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
    .words_in(words_in), .words_out(words_out), .overflow(overflow),
    .protocol_error(protocol_error), .done(done)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic wr(input logic [11:0] d);
    out_we = 1; out_data = d; step(); out_we = 0;
  endtask
  initial begin
    logic [11:0] exp_q [4] = '{12'd2, 12'd3, 12'd4, 12'd11};
    reset = 1; start = 0; out_we = 0; out_data = 0; prog_finished = 0; rd_ready = 0;
    step(); step();
    reset = 0;
    check("rst_valid", rd_valid, 0);
    check("rst_data", rd_data, 0);
    check("rst_counts", {words_in, words_out}, 0);
    check("rst_flags", {overflow, protocol_error, done}, 0);
    wr(12'd5);
    check("idle_perr", protocol_error, 1);
    check("idle_valid", rd_valid, 0);
    start = 1; step(); start = 0;
    check("start_clr_perr", protocol_error, 0);
    rd_ready = 1;
    out_we = 1; out_data = 3; step();
    check("seq_3", {rd_valid, rd_data}, {1'b1, 12'd3});
    out_data = 7; step();
    check("seq_7", {rd_valid, rd_data}, {1'b1, 12'd7});
    out_data = 9; step();
    check("seq_9", {rd_valid, rd_data}, {1'b1, 12'd9});
    out_we = 0; prog_finished = 1; step(); prog_finished = 0;
    check("seq_empty", rd_valid, 0);
    step(); step();
    check("seq_done", done, 1);
    check("seq_counts", {words_in, words_out}, {16'd3, 16'd3});
    wr(12'd6);
    check("done_perr", protocol_error, 1);
    check("done_valid", rd_valid, 0);
    start = 1; rd_ready = 0; step(); start = 0;
    check("restart", {done, protocol_error, words_in, words_out}, 0);
    for (int i = 1; i <= 4; i++) wr(12'(i));
    check("full_head", rd_data, 1);
    check("full_noovf", overflow, 0);
    rd_ready = 1; wr(12'd11); rd_ready = 0;
    check("fullhs_noovf", overflow, 0);
    check("fullhs_in", words_in, 5);
    check("fullhs_head", rd_data, 2);
    wr(12'd5);
    check("ovf", overflow, 1);
    check("ovf_in", words_in, 5);
    rd_ready = 1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_%0d", i), {rd_valid, rd_data}, {1'b1, exp_q[i]});
      step();
    end
    check("drain_empty", rd_valid, 0);
    check("drain_out", words_out, 5);
    rd_ready = 0;
    wr(12'd21); wr(12'd22);
    prog_finished = 1; step(); prog_finished = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("hold_done_%0d", i), done, 0);
      check($sformatf("hold_data_%0d", i), {rd_valid, rd_data}, {1'b1, 12'd21});
    end
    rd_ready = 1;
    check("dr_21", rd_data, 21);
    step();
    check("dr_22", rd_data, 22);
    step();
    check("dr_empty", rd_valid, 0);
    step();
    check("dr_done", done, 1);
    check("dr_counts", {words_in, words_out}, {16'd7, 16'd7});
    start = 1; rd_ready = 0; step(); start = 0;
    wr(12'd31); wr(12'd32); wr(12'd33);
    check("pre_rst_in", words_in, 3);
    reset = 1; step(); reset = 0;
    check("mid_rst_valid", rd_valid, 0);
    check("mid_rst_all", {words_in, words_out, overflow, protocol_error, done}, 0);
    wr(12'd1);
    check("mid_rst_idle", protocol_error, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
